// File: rtl/noc_chan_pkg.sv
// Shared mesh channel definitions: flit and flow-control field layout, head-flit
// fields, router address format and flit packing helpers.
package noc_chan_pkg;

  localparam int CHAN_W  = 38;
  localparam int FC_W    = 3;
  localparam int NUM_VCS = 4;
  localparam int VC_W    = 2;
  localparam int DATA_W  = 32;
  localparam int ADDR_W  = 4;

  localparam int CH_VALID = 0;
  localparam int CH_VC    = 1;
  localparam int CH_HEAD  = 3;
  localparam int CH_TAIL  = 4;
  localparam int CH_RSVD  = 5;
  localparam int CH_DATA  = 6;

  localparam int FC_VALID = 0;
  localparam int FC_VC    = 1;

  localparam int HD_DEST = 0;
  localparam int HD_SRC  = 4;
  localparam int HD_PAD  = 8;

  typedef struct packed {
    logic [1:0] x;
    logic [1:0] y;
  } router_addr_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BODY = 1'b1
  } nic_state_e;

  function automatic logic [0:DATA_W-1] head_data(
    input logic [0:ADDR_W-1] dest,
    input router_addr_t      src
  );
    logic [0:DATA_W-1] d;
    d = '0;
    d[HD_DEST +: ADDR_W] = dest;
    d[HD_SRC +: ADDR_W]  = {src.x, src.y};
    d[HD_PAD +: DATA_W-HD_PAD] = '0;
    return d;
  endfunction

  function automatic logic [0:CHAN_W-1] pack_flit(
    input logic [VC_W-1:0]   vc,
    input logic              head,
    input logic              tail,
    input logic [0:DATA_W-1] data
  );
    logic [0:CHAN_W-1] f;
    f = '0;
    f[CH_VALID]          = 1'b1;
    f[CH_VC +: VC_W]     = vc;
    f[CH_HEAD]           = head;
    f[CH_TAIL]           = tail;
    f[CH_RSVD]           = 1'b0;
    f[CH_DATA +: DATA_W] = data;
    return f;
  endfunction

endpackage

// File: rtl/nic_credit_ctr.sv
// Per-VC credit counter: saturating up/down count of free router buffer slots,
// with a full flag and a one-cycle overflow pulse on a surplus credit.
module nic_credit_ctr
  import noc_chan_pkg::*;
#(
  parameter int BUF_DEPTH = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           dec,
  input  logic                           inc,
  output logic [$clog2(BUF_DEPTH+1)-1:0] count,
  output logic                           full,
  output logic                           ovf
);

  localparam int CNT_W = $clog2(BUF_DEPTH + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(BUF_DEPTH);

  function automatic logic [CNT_W-1:0] sat_step(
    input logic [CNT_W-1:0] c,
    input logic             up,
    input logic             dn
  );
    if (up && !dn) return (c == MAX_CNT) ? c : c + 1'b1;
    if (dn && !up) return (c == '0) ? c : c - 1'b1;
    return c;
  endfunction

  assign full = (count == MAX_CNT);
  assign ovf  = inc && !dec && full;

  always_ff @(posedge clk) begin
    if (reset) count <= MAX_CNT;
    else       count <= sat_step(count, inc, dec);
  end

endmodule

// File: rtl/nic_inject.sv
// Host-to-router injection interface: frames host words into head/body/tail flits
// on the router local port, choosing a drained VC round-robin per packet.
module nic_inject
  import noc_chan_pkg::*;
#(
  parameter int         BUF_DEPTH      = 8,
  parameter logic [0:3] ROUTER_ADDRESS = 4'b0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_first,
  input  logic        in_last,
  input  logic [0:3]  in_dest,
  input  logic [0:31] in_data,
  output logic [0:37] channel_out,
  input  logic [0:2]  flow_ctrl_in,
  output logic        error
);

  localparam int CNT_W = $clog2(BUF_DEPTH + 1);
  localparam router_addr_t SRC_ADDR = router_addr_t'(ROUTER_ADDRESS);

  nic_state_e state, state_nxt;

  logic [VC_W-1:0]               cur_vc, rr_ptr, pick_vc;
  logic                          pick_ok, first_pend;
  logic [NUM_VCS-1:0][CNT_W-1:0] cnt;
  logic [NUM_VCS-1:0]            full, ovf, inc, dec;
  logic                          head_fire, word_fire, proto_err;
  logic [0:CHAN_W-1]             flit_nxt, flit_p1;
  logic                          fc_vld;
  logic [VC_W-1:0]               fc_vc;

  assign fc_vld = flow_ctrl_in[FC_VALID];
  assign fc_vc  = flow_ctrl_in[FC_VC +: VC_W];

  for (genvar v = 0; v < NUM_VCS; v++) begin : g_vc
    nic_credit_ctr #(.BUF_DEPTH(BUF_DEPTH)) u_ctr (
      .clk   (clk),
      .reset (reset),
      .dec   (dec[v]),
      .inc   (inc[v]),
      .count (cnt[v]),
      .full  (full[v]),
      .ovf   (ovf[v])
    );
  end

  // Scan from farthest to nearest after the pointer so the nearest drained VC wins.
  always_comb begin
    pick_ok = 1'b0;
    pick_vc = rr_ptr;
    for (int i = NUM_VCS; i >= 1; i--) begin
      if (full[rr_ptr + VC_W'(i)]) begin
        pick_ok = 1'b1;
        pick_vc = rr_ptr + VC_W'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (in_valid && in_first && pick_ok) state_nxt = ST_BODY;
      ST_BODY: if (in_valid && in_ready && in_last) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // The opening word is accepted in BODY with in_first still high; first_pend keeps it legal.
  always_comb begin
    in_ready  = 1'b0;
    head_fire = 1'b0;
    word_fire = 1'b0;
    proto_err = 1'b0;
    case (state)
      ST_IDLE: begin
        head_fire = in_valid && in_first && pick_ok;
        proto_err = in_valid && (!in_first || in_last);
      end
      ST_BODY: begin
        in_ready  = (cnt[cur_vc] != '0);
        word_fire = in_valid && in_ready;
        proto_err = in_valid && in_first && !first_pend;
      end
      default: ;
    endcase
  end

  always_comb begin
    for (int v = 0; v < NUM_VCS; v++) begin
      dec[v] = (head_fire && (pick_vc == VC_W'(v))) || (word_fire && (cur_vc == VC_W'(v)));
      inc[v] = fc_vld && (fc_vc == VC_W'(v));
    end
  end

  always_comb begin
    flit_nxt = '0;
    if (head_fire)      flit_nxt = pack_flit(pick_vc, 1'b1, 1'b0, head_data(in_dest, SRC_ADDR));
    else if (word_fire) flit_nxt = pack_flit(cur_vc, 1'b0, in_last, in_data);
  end

  // Stage p1: registered flit and packet bookkeeping
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr     <= VC_W'(NUM_VCS - 1);
      cur_vc     <= '0;
      first_pend <= 1'b0;
      error      <= 1'b0;
      flit_p1    <= '0;
    end else begin
      if (head_fire) begin
        rr_ptr     <= pick_vc;
        cur_vc     <= pick_vc;
        first_pend <= 1'b1;
      end else if (word_fire) begin
        first_pend <= 1'b0;
      end
      error   <= error | proto_err | (|ovf);
      flit_p1 <= flit_nxt;
    end
  end

  assign channel_out = flit_p1;

endmodule

// File: tb/tb_nic_inject.sv
// Directed bench for nic_inject: framing, credit starvation, VC round-robin,
// credit counter corner cases, protocol errors and reset mid-packet.
module tb_nic_inject;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready, in_first, in_last;
  logic [0:3]  in_dest;
  logic [0:31] in_data;
  logic [0:37] channel_out;
  logic [0:2]  flow_ctrl_in;
  logic        error;

  int n_checks = 0;
  int n_pass   = 0;

  nic_inject #(.BUF_DEPTH(8), .ROUTER_ADDRESS(4'b0000)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_first     (in_first),
    .in_last      (in_last),
    .in_dest      (in_dest),
    .in_data      (in_data),
    .channel_out  (channel_out),
    .flow_ctrl_in (flow_ctrl_in),
    .error        (error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [0:37] exp_flit(input logic [1:0] vc, input logic hd,
                                           input logic tl, input logic [31:0] d);
    return {1'b1, vc, hd, tl, 1'b0, d};
  endfunction

  function automatic logic [31:0] exp_head(input logic [3:0] dest);
    return {dest, 4'b0000, 24'h0};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
    in_dest = 4'h0; in_data = 32'h0; flow_ctrl_in = 3'b000;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic run_pkt(input string tag, input logic [1:0] vc, input logic [3:0] dest,
                         input logic [31:0] d1, input logic [31:0] d2);
    in_valid = 1'b1; in_first = 1'b1; in_last = 1'b0; in_dest = dest; in_data = d1;
    tick();
    chk({tag, "_head"}, channel_out, exp_flit(vc, 1'b1, 1'b0, exp_head(dest)));
    tick();
    chk({tag, "_body"}, channel_out, exp_flit(vc, 1'b0, 1'b0, d1));
    in_first = 1'b0; in_last = 1'b1; in_data = d2;
    tick();
    chk({tag, "_tail"}, channel_out, exp_flit(vc, 1'b0, 1'b1, d2));
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  initial begin
    // Reset state and a 3-word packet
    do_reset();
    chk("rst_chan", channel_out, 38'h0);
    chk("rst_ready", in_ready, 1'b0);
    chk("rst_error", error, 1'b0);
    chk("rst_cnt0", dut.cnt[0], 4'd8);
    in_valid = 1'b1; in_first = 1'b1; in_last = 1'b0; in_dest = 4'b0101; in_data = 32'hA1A1_0001;
    tick();
    chk("p1_head", channel_out, exp_flit(2'd0, 1'b1, 1'b0, 32'h5000_0000));
    chk("p1_ready", in_ready, 1'b1);
    tick();
    chk("p1_body1", channel_out, exp_flit(2'd0, 1'b0, 1'b0, 32'hA1A1_0001));
    in_first = 1'b0; in_data = 32'hA1A1_0002;
    tick();
    chk("p1_body2", channel_out, exp_flit(2'd0, 1'b0, 1'b0, 32'hA1A1_0002));
    in_last = 1'b1; in_data = 32'hA1A1_0003;
    tick();
    chk("p1_tail", channel_out, exp_flit(2'd0, 1'b0, 1'b1, 32'hA1A1_0003));
    chk("p1_ready_idle", in_ready, 1'b0);
    in_valid = 1'b0; in_last = 1'b0;
    tick();
    chk("p1_idle_chan", channel_out, 38'h0);
    chk("p1_cnt0", dut.cnt[0], 4'd4);
    chk("p1_error", error, 1'b0);

    // Credit starvation on VC0 with a 9-word packet
    do_reset();
    in_valid = 1'b1; in_first = 1'b1; in_dest = 4'b1010; in_data = 32'h0000_B001;
    tick();
    chk("st_head", channel_out, exp_flit(2'd0, 1'b1, 1'b0, 32'hA000_0000));
    for (int k = 1; k <= 7; k++) begin
      chk($sformatf("st_ready_w%0d", k), in_ready, 1'b1);
      tick();
      chk($sformatf("st_body_w%0d", k), channel_out, exp_flit(2'd0, 1'b0, 1'b0, 32'h0000_B000 + k));
      in_first = 1'b0; in_data = 32'h0000_B000 + k + 1;
    end
    chk("st_ready_drop", in_ready, 1'b0);
    flow_ctrl_in = 3'b100;
    tick();
    flow_ctrl_in = 3'b000;
    chk("st_ready_credit", in_ready, 1'b1);
    chk("st_stall_chan", channel_out, 38'h0);
    tick();
    chk("st_body_w8", channel_out, exp_flit(2'd0, 1'b0, 1'b0, 32'h0000_B008));
    chk("st_ready_drop2", in_ready, 1'b0);
    in_last = 1'b1; in_data = 32'h0000_B009;
    flow_ctrl_in = 3'b100;
    tick();
    flow_ctrl_in = 3'b000;
    chk("st_ready_credit2", in_ready, 1'b1);
    tick();
    chk("st_tail", channel_out, exp_flit(2'd0, 1'b0, 1'b1, 32'h0000_B009));
    in_valid = 1'b0; in_last = 1'b0;
    chk("st_cnt0", dut.cnt[0], 4'd0);
    chk("st_error", error, 1'b0);

    // Round-robin over drained VCs, then a stall until VC0 drains
    do_reset();
    run_pkt("rr0", 2'd0, 4'b0001, 32'hC000_0001, 32'hC000_0002);
    run_pkt("rr1", 2'd1, 4'b0010, 32'hC100_0001, 32'hC100_0002);
    run_pkt("rr2", 2'd2, 4'b0011, 32'hC200_0001, 32'hC200_0002);
    run_pkt("rr3", 2'd3, 4'b0100, 32'hC300_0001, 32'hC300_0002);
    in_valid = 1'b1; in_first = 1'b1; in_dest = 4'b1111; in_data = 32'hC400_0001;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("rr_stall%0d", k), channel_out, 38'h0);
    end
    for (int k = 0; k < 3; k++) begin
      flow_ctrl_in = 3'b100;
      tick();
      chk($sformatf("rr_wait_credit%0d", k), channel_out, 38'h0);
    end
    flow_ctrl_in = 3'b000;
    tick();
    chk("rr4_head", channel_out, exp_flit(2'd0, 1'b1, 1'b0, exp_head(4'b1111)));
    in_first = 1'b0; in_last = 1'b1;
    tick();
    chk("rr4_tail", channel_out, exp_flit(2'd0, 1'b0, 1'b1, 32'hC400_0001));
    in_valid = 1'b0; in_last = 1'b0;
    chk("rr_error", error, 1'b0);

    // Send and credit on VC0 in the same cycle, then overflow
    do_reset();
    in_valid = 1'b1; in_first = 1'b1; in_dest = 4'b0110; in_data = 32'hD000_0001;
    tick();
    chk("sc_cnt_head", dut.cnt[0], 4'd7);
    flow_ctrl_in = 3'b100;
    tick();
    flow_ctrl_in = 3'b000;
    chk("sc_cnt_same", dut.cnt[0], 4'd7);
    in_first = 1'b0; in_last = 1'b1; in_data = 32'hD000_0002;
    tick();
    in_valid = 1'b0; in_last = 1'b0;
    chk("sc_cnt_tail", dut.cnt[0], 4'd6);
    flow_ctrl_in = 3'b100;
    tick(); tick();
    chk("sc_cnt_full", dut.cnt[0], 4'd8);
    chk("sc_no_error", error, 1'b0);
    tick();
    flow_ctrl_in = 3'b000;
    chk("ovf_cnt", dut.cnt[0], 4'd8);
    tick();
    chk("ovf_error", error, 1'b1);

    // Body word with no in_first while idle
    do_reset();
    chk("pe_rst_error", error, 1'b0);
    in_valid = 1'b1; in_first = 1'b0; in_data = 32'hE000_0001;
    tick();
    chk("pe_ready", in_ready, 1'b0);
    chk("pe_chan", channel_out, 38'h0);
    chk("pe_error", error, 1'b1);
    in_valid = 1'b0;

    // Reset mid-packet, then a fresh packet on VC0
    do_reset();
    run_pkt("mr_pre", 2'd0, 4'b0011, 32'hF000_0001, 32'hF000_0002);
    in_valid = 1'b1; in_first = 1'b1; in_dest = 4'b1001; in_data = 32'hF100_0001;
    tick();
    chk("mr_head", channel_out, exp_flit(2'd1, 1'b1, 1'b0, exp_head(4'b1001)));
    tick();
    chk("mr_body", channel_out, exp_flit(2'd1, 1'b0, 1'b0, 32'hF100_0001));
    in_first = 1'b0; in_data = 32'hF100_0002; reset = 1'b1;
    tick();
    chk("mr_chan", channel_out, 38'h0);
    chk("mr_ready", in_ready, 1'b0);
    reset = 1'b0; in_valid = 1'b0;
    tick();
    chk("mr_idle_chan", channel_out, 38'h0);
    run_pkt("mr_post", 2'd0, 4'b1100, 32'hF200_0001, 32'hF200_0002);
    chk("mr_error", error, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
